mat_result_serializer: RTL and testbench
========================================

MAT_RESULT_SERIALIZER -- requirements
Module: mat_result_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bit width of one matrix element.
REQ-002 SHALL have parameter ROWS, default 4: rows of the result matrix (equals ROWS_A of the multiplier).
REQ-003 SHALL have parameter COLS, default 4: columns of the result matrix (equals COLS_B of the multiplier).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port c, input, [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0]: packed result matrix from the multiplier.
REQ-008 SHALL have port c_valid, input, 1: c is valid (driven by the multiplier's out_valid).
REQ-009 SHALL have port c_ready, output, 1: serializer accepts c (drives the multiplier's out_ready).
REQ-010 SHALL have port m_data, output, DATA_WIDTH: streamed element.
REQ-011 SHALL have port m_valid, output, 1: m_data valid.
REQ-012 SHALL have port m_ready, input, 1: downstream accepts m_data.
REQ-013 SHALL have port m_last, output, 1: current beat is element [ROWS-1][COLS-1].
REQ-014 SHALL have port frames, output, 32: count of fully streamed matrices.

Function
REQ-015 SHALL implement an FSM with states IDLE and SEND.
REQ-016 In IDLE: c_ready=1 and m_valid=0.
REQ-017 On c_valid&&c_ready at a rising edge: register all of c into an internal buffer, set row=0 and col=0, and enter SEND.
REQ-018 In SEND: c_ready=0, m_valid=1, m_data=buffer[row][col] (registered value), m_last=(row==ROWS-1 && col==COLS-1).
REQ-019 First m_valid SHALL assert in the cycle after the c handshake (latency 1).
REQ-020 On m_valid&&m_ready: col increments; at col==COLS-1, col wraps to 0 and row increments (row-major order).
REQ-021 On acceptance of the m_last beat: return to IDLE and increment frames by 1 (wraps at 2^32-1 -> 0).
REQ-022 While m_valid&&!m_ready: m_data, m_last, row and col SHALL hold stable.
REQ-023 The buffer SHALL NOT change during SEND regardless of c or c_valid.
REQ-024 Throughput with m_ready held at 1: ROWS*COLS+1 cycles per matrix (ROWS*COLS beats + 1 IDLE capture cycle).
REQ-025 With ROWS=COLS=1: single beat with m_last=1.
REQ-026 m_data, m_last and m_valid SHALL be driven only from registers or FSM state (no combinational path from m_ready).

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, row=col=0, m_valid=0, m_last=0, m_data=0, frames=0, and buffer contents to 0.
REQ-028 With rst held: c_ready=0.
REQ-029 After rst deasserts: c_ready=1 from the next cycle.
REQ-030 Reset mid-SEND SHALL discard the partial matrix without incrementing frames.

Structure
REQ-031 Shared package mat_pkg SHALL hold the FSM state enum and the default DATA_WIDTH/ROWS/COLS constants.
REQ-032 Row/column wrap counting SHALL be one sub-module mat_idx_counter:
- parameters ROWS and COLS
- inputs en and clr
- outputs row, col and last

Verification
REQ-033 Scenario 1, basic stream (ROWS=COLS=4, c[i][j]=16*i+j, m_ready=1):
- m_data sequence 0,1,2,3,16,...,51
- m_last only on 51
- frames=1
- 17 cycles total
REQ-034 Scenario 2, backpressure: toggle m_ready 1,0,0,1,...
- all 16 values arrive in order
- m_data stable during stalls
- no duplicates or drops
REQ-035 Scenario 3, source change: change c and hold c_valid=1 during SEND.
- c_ready=0 throughout SEND
- streamed values equal the first captured matrix
- second matrix is captured in the IDLE cycle after m_last
REQ-036 Scenario 4, reset mid-operation: assert rst after beat 5 of 16.
- m_valid=0 immediately
- frames stays 0
- a new matrix then streams from element [0][0]
REQ-037 Scenario 5, counter and corner case:
- stream 3 back-to-back matrices -> frames=3
- ROWS=COLS=1 build -> single beat with m_last=1

Source files
------------

// File: rtl/mat_pkg.sv
// ---------------------------------------------------------------------------
// mat_pkg
// Shared definitions for the matrix result serializer slice:
//   - default element width and matrix dimensions
//   - serializer FSM state encoding
//   - index-width helper (keeps 1-wide counters legal for 1x1 builds)
// ---------------------------------------------------------------------------
package mat_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// ---------------------------------------------------------------------------
// mat_idx_counter
// Row-major (row, col) walker over a ROWS x COLS matrix.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears row/col
//   en    - advance one element (col first, wrap into row)
//   clr   - return to element [0][0]; wins over en
//   row   - current row index
//   col   - current column index
//   last  - current element is [ROWS-1][COLS-1]
// ---------------------------------------------------------------------------
module mat_idx_counter
    import mat_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    localparam int RW  = idx_width(ROWS),
    localparam int CW  = idx_width(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                // Wrapping past the final row lands back on [0][0] ready for the next frame.
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/mat_result_serializer.sv
// ---------------------------------------------------------------------------
// mat_result_serializer
// Captures a whole ROWS x COLS result matrix in one handshake and streams it
// out one element per accepted beat in row-major order.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   c        - packed result matrix from the multiplier
//   c_valid  - c is valid
//   c_ready  - serializer can take a new matrix (IDLE, out of reset)
//   m_data   - streamed element
//   m_valid  - m_data valid
//   m_ready  - downstream accepts m_data
//   m_last   - current beat is element [ROWS-1][COLS-1]
//   frames   - number of fully streamed matrices (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | buffer free; c_ready high once out of reset, capture on c_valid
// SEND  | streaming buffer[row][col]; input side closed until m_last taken
// ---------------------------------------------------------------------------
module mat_result_serializer
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0] c,
    input  logic                                     c_valid,
    output logic                                     c_ready,
    output logic [DATA_WIDTH-1:0]                    m_data,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic                                     m_last,
    output logic [31:0]                              frames
);

    localparam int RW = idx_width(ROWS);
    localparam int CW = idx_width(COLS);

    state_t state_q, state_d;

    logic [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0] buf_q, buf_d;
    logic [31:0]   frames_q, frames_d;
    // Low during reset and for the first edge after it, so c_ready stays low while rst is held.
    logic          rdy_q;

    logic          capture;
    logic          beat;
    logic          frame_done;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          idx_last;
    logic [DATA_WIDTH-1:0] sel_data;

    mat_idx_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .en   (beat),
        .clr  (capture),
        .row  (row),
        .col  (col),
        .last (idx_last)
    );

    always_comb begin
        state_d    = state_q;
        c_ready    = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        capture    = 1'b0;
        beat       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                c_ready = rdy_q;
                if (c_valid && rdy_q) begin
                    capture = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_last  = idx_last;
                if (m_ready) begin
                    beat = 1'b1;
                    if (idx_last) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer only loads on the IDLE handshake, so c is ignored for the whole of SEND.
    assign buf_d    = capture ? c : buf_q;
    assign frames_d = frame_done ? frames_q + 32'd1 : frames_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            frames_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            frames_q <= frames_d;
            rdy_q    <= 1'b1;
        end
    end

    // Element select as a compare-mux over registered indices; avoids index-width
    // mismatches on degenerate 1-row or 1-column builds.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                if ((row == RW'(i)) && (col == CW'(j))) begin
                    sel_data = buf_q[i][j];
                end
            end
        end
    end

    assign m_data = sel_data;
    assign frames = frames_q;

endmodule

// File: tb/tb_mat_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_mat_result_serializer
// Directed bench for the 4x4 serializer plus a 1x1 corner build.
// ---------------------------------------------------------------------------
module tb_mat_result_serializer;

    localparam int DW = 32;
    localparam int R  = 4;
    localparam int C  = 4;

    logic clk = 1'b0;
    logic rst;

    logic [0:R-1][0:C-1][DW-1:0] c;
    logic          c_valid, c_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready, m_last;
    logic [31:0]   frames;

    logic [0:0][0:0][DW-1:0] c1;
    logic          c1_valid, c1_ready;
    logic [DW-1:0] m1_data;
    logic          m1_valid, m1_ready, m1_last;
    logic [31:0]   frames1;

    always #5 clk = ~clk;

    mat_result_serializer #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst), .c(c), .c_valid(c_valid), .c_ready(c_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .frames(frames)
    );

    mat_result_serializer #(.DATA_WIDTH(DW), .ROWS(1), .COLS(1)) dut1 (
        .clk(clk), .rst(rst), .c(c1), .c_valid(c1_valid), .c_ready(c1_ready),
        .m_data(m1_data), .m_valid(m1_valid), .m_ready(m1_ready),
        .m_last(m1_last), .frames(frames1)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;
    exp_t sb[$];

    int beats = 0;
    int lasts = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                c[i][j] = DW'(base + 16 * i + j);
    endtask

    task automatic push(input int base);
        exp_t e;
        for (int i = 0; i < R; i++) begin
            for (int j = 0; j < C; j++) begin
                e.d = DW'(base + 16 * i + j);
                e.l = (i == R - 1) && (j == C - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (sb.size() == 0 && c_ready) done = 1'b1;
            else step();
        end
        chk(tag, done, 1'b1);
    endtask

    // Output monitor: scoreboard pop on accepted beats, stall stability, closed input in SEND.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_d;
    logic          stall_l;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, stall_d);
                chk("stall_last", m_last, stall_l);
            end
            if (m_valid) chk("send_c_ready", c_ready, 1'b0);
            if (m_valid && m_ready) begin
                chk("sb_nonempty", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_last", m_last, e.l);
                end
                beats++;
                if (m_last) lasts++;
            end
            stall_prev = m_valid && !m_ready;
            stall_d    = m_data;
            stall_l    = m_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy;
        int   b0;
        int   l0;
        logic done;
        logic pat [4];

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        rst = 1'b1; c = '0; c_valid = 1'b0; m_ready = 1'b1;
        c1 = '0; c1_valid = 1'b0; m1_ready = 1'b1;

        // Reset state with rst held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c_ready", c_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_frames", frames, '0);
        chk("rst_c1_ready", c1_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_c_ready_same_cycle", c_ready, 1'b0);
        step();
        chk("rel_c_ready_next", c_ready, 1'b1);

        // Scenario 1: basic stream, m_ready held high
        load(0); push(0);
        b0 = beats; l0 = lasts;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        chk("s1_latency_valid", m_valid, 1'b1);
        chk("s1_first_data", m_data, 0);
        busy = 0;
        while (!c_ready && busy < 100) begin
            step();
            busy++;
        end
        chk("s1_cycles", busy + 1, 17);
        chk("s1_sb_empty", sb.size(), 0);
        chk("s1_beats", beats - b0, 16);
        chk("s1_lasts", lasts - l0, 1);
        chk("s1_frames", frames, 1);

        // Scenario 2: backpressure 1,0,0,1,...
        load(256); push(256);
        b0 = beats;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (sb.size() == 0 && c_ready) done = 1'b1;
            else begin
                m_ready = pat[k % 4];
                step();
            end
        end
        m_ready = 1'b1;
        chk("s2_done", done, 1'b1);
        chk("s2_beats", beats - b0, 16);
        chk("s2_frames", frames, 2);

        // Scenario 3: source changes while streaming, c_valid held
        load(512); push(512);
        c_valid = 1'b1;
        step();
        load(768); push(768);
        for (int k = 0; k < 16; k++) step();
        chk("s3_idle_after_last", c_ready, 1'b1);
        chk("s3_frames_a", frames, 3);
        step();
        chk("s3_second_captured", m_valid, 1'b1);
        load(28672);
        repeat (3) step();
        c_valid = 1'b0;
        drain("s3_drain");
        chk("s3_frames_b", frames, 4);

        // Scenario 4: reset after beat 5 of 16
        load(1024); push(1024);
        b0 = beats;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        repeat (5) step();
        chk("s4_beats_before_rst", beats - b0, 5);
        rst = 1'b1;
        #1;
        chk("s4_m_valid", m_valid, 1'b0);
        chk("s4_m_last", m_last, 1'b0);
        chk("s4_m_data", m_data, '0);
        chk("s4_c_ready", c_ready, 1'b0);
        chk("s4_frames", frames, 0);
        sb.delete();
        step();
        rst = 1'b0;
        step();
        chk("s4_frames_after", frames, 0);
        load(1280); push(1280);
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        chk("s4_restart_data", m_data, 1280);
        drain("s4_drain");
        chk("s4_frames_new", frames, 1);

        // Scenario 5: three back-to-back matrices after a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        load(1536); push(1536); push(1536); push(1536);
        b0 = beats;
        c_valid = 1'b1;
        for (int k = 0; k < 35; k++) step();
        c_valid = 1'b0;
        chk("s5_third_in_send", m_valid, 1'b1);
        drain("s5_drain");
        chk("s5_beats", beats - b0, 48);
        chk("s5_frames", frames, 3);

        // 1x1 build: single beat with m_last
        c1[0][0] = 32'hABCD_0001;
        c1_valid = 1'b1;
        step();
        c1_valid = 1'b0;
        chk("x1_valid", m1_valid, 1'b1);
        chk("x1_last", m1_last, 1'b1);
        chk("x1_data", m1_data, 32'hABCD_0001);
        chk("x1_c_ready_busy", c1_ready, 1'b0);
        step();
        chk("x1_valid_after", m1_valid, 1'b0);
        chk("x1_frames", frames1, 1);
        chk("x1_c_ready_idle", c1_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
